// File: rtl/sound_chord_player_if.sv
// Key/control inputs and tone/status outputs of the chord player.
`timescale 1ns/1ps
interface sound_chord_player_if #(
  parameter int NUM_KEYS = 8
);
  localparam int CW = $clog2(NUM_KEYS + 1);

  logic [NUM_KEYS-1:0] keys;
  logic [1:0]          mode;
  logic [1:0]          shift;
  logic                mute;
  logic                pwm;
  logic                sd;
  logic                active;
  logic [3:0]          cur_note;
  logic [CW-1:0]       note_cnt;

  modport master (output keys, mode, shift, mute,
                  input  pwm, sd, active, cur_note, note_cnt);
  modport slave  (input  keys, mode, shift, mute,
                  output pwm, sd, active, cur_note, note_cnt);
endinterface

// File: rtl/sound_chord_player.sv
// Polyphonic key-to-tone player: compacts held keys into an ascending note
// list, then arpeggiates or plays the lowest/highest note as a square wave.
`timescale 1ns/1ps
module sound_chord_player #(
  parameter int NUM_KEYS     = 8,
  parameter int CLK_HZ       = 100000000,
  parameter int SLICE_CYCLES = 5000000
) (
  input logic                 clk,
  input logic                 rst,
  sound_chord_player_if.slave bus
);
  localparam int CW = $clog2(NUM_KEYS + 1);
  localparam int LN = 1 << CW;

  typedef enum logic [1:0] {IDLE, SCAN, PLAY} state_t;

  function automatic logic [31:0] half_of(input logic [3:0] n);
    case (n)
      4'd0:    half_of = 32'(CLK_HZ / 524);
      4'd1:    half_of = 32'(CLK_HZ / 554);
      4'd2:    half_of = 32'(CLK_HZ / 588);
      4'd3:    half_of = 32'(CLK_HZ / 622);
      4'd4:    half_of = 32'(CLK_HZ / 660);
      4'd5:    half_of = 32'(CLK_HZ / 698);
      4'd6:    half_of = 32'(CLK_HZ / 740);
      4'd7:    half_of = 32'(CLK_HZ / 784);
      4'd8:    half_of = 32'(CLK_HZ / 830);
      4'd9:    half_of = 32'(CLK_HZ / 880);
      4'd10:   half_of = 32'(CLK_HZ / 932);
      4'd11:   half_of = 32'(CLK_HZ / 988);
      default: half_of = '0;
    endcase
  endfunction

  function automatic logic [31:0] eff_half(input logic [3:0] n, input logic [1:0] sh);
    logic [31:0] h;
    h = half_of(n);
    case (sh)
      2'd0:    eff_half = h << 1;
      2'd1:    eff_half = h;
      2'd2:    eff_half = h >> 1;
      default: eff_half = h >> 2;
    endcase
  endfunction

  state_t              state;
  logic [NUM_KEYS-1:0] keys_q;
  logic [LN-1:0]       keys_pad;
  logic [3:0]          list [LN];
  logic [CW-1:0]       scan, wp, play_idx, note_cnt;
  logic [31:0]         slot, tone, half_eff;
  logic                pwm_q, sd_q, active_q;
  logic [3:0]          cur_note_q;

  logic                change, hit, scan_last, tone_hit, pwm_nxt;
  logic [CW-1:0]       cnt_fin, pidx, nidx, adv_idx;
  logic [3:0]          first_note, last_note, start_note, adv_note;
  logic [31:0]         tone_nxt;

  assign keys_pad  = {{(LN-NUM_KEYS){1'b0}}, keys_q};
  assign change    = bus.keys != keys_q;
  assign hit       = keys_pad[scan];
  assign scan_last = scan == CW'(NUM_KEYS - 1);
  assign cnt_fin   = wp + CW'(hit);

  // The final key may be written on the same edge PLAY starts, so the
  // first/last note is resolved from the in-flight scan result as well.
  assign first_note = (wp == '0) ? 4'(scan) : list[0];
  assign last_note  = hit ? 4'(scan) : list[wp - 1'b1];
  assign start_note = (bus.mode == 2'd2) ? last_note : first_note;

  assign pidx = (play_idx >= note_cnt) ? '0 : play_idx;
  assign nidx = (pidx + 1'b1 == note_cnt) ? '0 : pidx + 1'b1;

  always_comb begin
    adv_note = list[nidx];
    adv_idx  = nidx;
    case (bus.mode)
      2'd1:    begin adv_note = list[0];                 adv_idx = pidx; end
      2'd2:    begin adv_note = list[note_cnt - 1'b1];   adv_idx = pidx; end
      default: begin adv_note = list[nidx];              adv_idx = nidx; end
    endcase
  end

  assign tone_hit = tone == half_eff - 32'd1;
  assign tone_nxt = tone_hit ? '0 : tone + 32'd1;
  assign pwm_nxt  = pwm_q ^ tone_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      keys_q     <= '0;
      scan       <= '0;
      wp         <= '0;
      play_idx   <= '0;
      note_cnt   <= '0;
      slot       <= '0;
      tone       <= '0;
      half_eff   <= '0;
      pwm_q      <= 1'b0;
      sd_q       <= 1'b0;
      active_q   <= 1'b0;
      cur_note_q <= '0;
      for (int i = 0; i < LN; i++) list[i] <= '0;
    end else begin
      sd_q   <= 1'b1;
      keys_q <= bus.keys;
      if (state != IDLE && change) begin
        state      <= (bus.keys == '0) ? IDLE : SCAN;
        scan       <= '0;
        wp         <= '0;
        play_idx   <= '0;
        slot       <= '0;
        tone       <= '0;
        pwm_q      <= 1'b0;
        active_q   <= 1'b0;
        cur_note_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            pwm_q      <= 1'b0;
            active_q   <= 1'b0;
            cur_note_q <= '0;
            if (change && bus.keys != '0) begin
              state <= SCAN;
              scan  <= '0;
              wp    <= '0;
            end
          end
          SCAN: begin
            if (hit) begin
              list[wp] <= 4'(scan);
              wp       <= wp + 1'b1;
            end
            scan <= scan + 1'b1;
            if (scan_last) begin
              note_cnt <= cnt_fin;
              if (cnt_fin != '0) begin
                state      <= PLAY;
                active_q   <= 1'b1;
                cur_note_q <= start_note;
                half_eff   <= eff_half(start_note, bus.shift);
                tone       <= '0;
                pwm_q      <= 1'b0;
                slot       <= '0;
                play_idx   <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
          PLAY: begin
            if (slot == 32'(SLICE_CYCLES - 1)) begin
              slot     <= '0;
              play_idx <= adv_idx;
              // Re-selecting the sounding note keeps its phase running.
              if (adv_note != cur_note_q) begin
                cur_note_q <= adv_note;
                half_eff   <= eff_half(adv_note, bus.shift);
                tone       <= '0;
                pwm_q      <= 1'b0;
              end else begin
                tone  <= tone_nxt;
                pwm_q <= pwm_nxt;
              end
            end else begin
              slot  <= slot + 32'd1;
              tone  <= tone_nxt;
              pwm_q <= pwm_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pwm      = pwm_q & ~bus.mute;
  assign bus.sd       = sd_q;
  assign bus.active   = active_q;
  assign bus.cur_note = cur_note_q;
  assign bus.note_cnt = note_cnt;
endmodule
